// File: rtl/wb8_bus_arbiter.sv
// Two-master round-robin arbiter for the shared 8-bit Wishbone bus; grant is held for a full CYC burst.
// Optional stuck-cycle watchdog is compiled in with `define WB8_ARB_TIMEOUT_EN.
module wb8_bus_arbiter #(
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic        I_wb_clk,
    input  logic        I_reset_n,
    input  logic        I_m0_cyc,
    input  logic        I_m0_stb,
    input  logic        I_m0_we,
    input  logic [31:0] I_m0_adr,
    input  logic [7:0]  I_m0_dat,
    output logic [7:0]  O_m0_dat,
    output logic        O_m0_ack,
    output logic        O_m0_stall,
    input  logic        I_m1_cyc,
    input  logic        I_m1_stb,
    input  logic        I_m1_we,
    input  logic [31:0] I_m1_adr,
    input  logic [7:0]  I_m1_dat,
    output logic [7:0]  O_m1_dat,
    output logic        O_m1_ack,
    output logic        O_m1_stall,
    output logic        O_s_cyc,
    output logic        O_s_stb,
    output logic        O_s_we,
    output logic [31:0] O_s_adr,
    output logic [7:0]  O_s_dat,
    input  logic [7:0]  I_s_dat,
    input  logic        I_s_ack,
    input  logic        I_s_stall,
    output logic [1:0]  O_grant,
    output logic        O_timeout
);

    typedef enum logic [1:0] {IDLE = 2'd0, OWN0 = 2'd1, OWN1 = 2'd2} state_t;

    state_t state, state_next;
    logic   last, last_next;   // master served most recently: 0 = M0, 1 = M1
    logic   timeout_hit;

    always_ff @(posedge I_wb_clk or negedge I_reset_n) begin
        if (!I_reset_n) begin
            state <= IDLE;
            last  <= 1'b1;
        end else begin
            state <= state_next;
            last  <= last_next;
        end
    end

    always_comb begin
        state_next = state;
        last_next  = last;
        case (state)
            IDLE: begin
                if (I_m0_cyc && I_m1_cyc) state_next = last ? OWN0 : OWN1;
                else if (I_m0_cyc)        state_next = OWN0;
                else if (I_m1_cyc)        state_next = OWN1;
            end
            OWN0: begin
                if (!I_m0_cyc) begin
                    last_next  = 1'b0;
                    state_next = I_m1_cyc ? OWN1 : IDLE;
                end
            end
            OWN1: begin
                if (!I_m1_cyc) begin
                    last_next  = 1'b1;
                    state_next = I_m0_cyc ? OWN0 : IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

`ifdef WB8_ARB_TIMEOUT_EN
    logic [15:0] wdog_cnt;

    // Counts strobed cycles without an ack; any grant movement restarts the window.
    always_ff @(posedge I_wb_clk or negedge I_reset_n) begin
        if (!I_reset_n)
            wdog_cnt <= 16'd0;
        else if (state == IDLE || state_next != state || I_s_ack || timeout_hit)
            wdog_cnt <= 16'd0;
        else if (O_s_stb)
            wdog_cnt <= wdog_cnt + 16'd1;
    end

    assign timeout_hit = (state != IDLE) && (wdog_cnt == 16'(TIMEOUT_CYCLES));
`else
    assign timeout_hit = 1'b0;
`endif

    assign O_timeout = timeout_hit;

    always_comb begin
        O_grant    = 2'b00;
        O_s_cyc    = 1'b0;
        O_s_stb    = 1'b0;
        O_s_we     = 1'b0;
        O_s_adr    = 32'd0;
        O_s_dat    = 8'd0;
        O_m0_dat   = 8'd0;
        O_m0_ack   = 1'b0;
        O_m0_stall = 1'b1;
        O_m1_dat   = 8'd0;
        O_m1_ack   = 1'b0;
        O_m1_stall = 1'b1;
        case (state)
            OWN0: begin
                O_grant    = 2'b01;
                O_s_cyc    = I_m0_cyc;
                O_s_stb    = I_m0_stb && !timeout_hit;
                O_s_we     = I_m0_we;
                O_s_adr    = I_m0_adr;
                O_s_dat    = I_m0_dat;
                O_m0_dat   = timeout_hit ? 8'hFF : I_s_dat;
                O_m0_ack   = I_s_ack || timeout_hit;
                O_m0_stall = I_s_stall;
            end
            OWN1: begin
                O_grant    = 2'b10;
                O_s_cyc    = I_m1_cyc;
                O_s_stb    = I_m1_stb && !timeout_hit;
                O_s_we     = I_m1_we;
                O_s_adr    = I_m1_adr;
                O_s_dat    = I_m1_dat;
                O_m1_dat   = timeout_hit ? 8'hFF : I_s_dat;
                O_m1_ack   = I_s_ack || timeout_hit;
                O_m1_stall = I_s_stall;
            end
            default: ;
        endcase
    end

endmodule
